muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit with HI/LO result registers.
- Sits beside the ALU in the EX stage of the five-stage pipeline and executes MULT, MULTU, DIV and DIVU over many cycles.
- While an operation is in flight, `busy` drives the hazard detection unit to stall any instruction that reads or writes HI/LO.
- Also supports direct HI/LO writes (MTHI/MTLO) and reports divide-by-zero.

---
 rtl/muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_muldiv_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract
// for divide. Signs are stripped on entry and the result is fixed up in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               is_div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               dbz_q;
  logic [WIDTH-1:0]   mag_b_q;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               dbz_out_q;

  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a_d;
  logic [WIDTH-1:0]   mag_b_d;

  assign signed_op = ~op_i[0];
  assign a_neg     = signed_op & a_i[WIDTH-1];
  assign b_neg     = signed_op & b_i[WIDTH-1];
  assign mag_a_d   = a_neg ? -a_i : a_i;
  assign mag_b_d   = b_neg ? -b_i : b_i;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;

  // Next accumulator for one RUN step, and the sign-corrected result for FIX.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, mag_b_q};
    if (!is_div_q) begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    prod_fix = neg_res_q ? -acc_q : acc_q;
    quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (!is_div_q) begin
      hi_d = prod_fix[2*WIDTH-1:WIDTH];
      lo_d = prod_fix[WIDTH-1:0];
    end else begin
      // A zero divisor leaves the dividend magnitude in the remainder, so the
      // sign fix already restores HI = a; only LO needs forcing.
      hi_d = rem_fix;
      lo_d = dbz_q ? '1 : quot_fix;
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      mag_b_q   <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hi_we_i) hi_q <= wdata_i;
          if (lo_we_i) lo_q <= wdata_i;
          if (start_i) begin
            is_div_q  <= op_i[1];
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dbz_q     <= op_i[1] & (b_i == '0);
            mag_b_q   <= mag_b_d;
            acc_q     <= {{WIDTH{1'b0}}, mag_a_d};
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          hi_q      <= hi_d;
          lo_q      <= lo_d;
          done_q    <= 1'b1;
          dbz_out_q <= dbz_q;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign div_by_zero_o = dbz_out_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: cycle-level reference model compared every cycle,
// plus literal expectations for the directed cases at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a = '0, b = '0, wdata = '0;
  logic         hi_we = 1'b0, lo_we = 1'b0;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  logic         s8_start = 1'b0;
  logic [1:0]   s8_op = 2'd0;
  logic [7:0]   s8_a = '0, s8_b = '0, s8_wdata = '0;
  logic         s8_hi_we = 1'b0, s8_lo_we = 1'b0;
  logic         busy8, done8, dbz8;
  logic [7:0]   hi8, lo8;

  muldiv_unit #(.WIDTH(W)) u32 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .hi_we_i(hi_we), .lo_we_i(lo_we), .wdata_i(wdata),
    .busy_o(busy), .done_o(done), .div_by_zero_o(dbz), .hi_o(hi), .lo_o(lo)
  );

  muldiv_unit #(.WIDTH(8)) u8 (
    .clk_i(clk), .rst_i(rst), .start_i(s8_start), .op_i(s8_op), .a_i(s8_a), .b_i(s8_b),
    .hi_we_i(s8_hi_we), .lo_we_i(s8_lo_we), .wdata_i(s8_wdata),
    .busy_o(busy8), .done_o(done8), .div_by_zero_o(dbz8), .hi_o(hi8), .lo_o(lo8)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Architectural result of one operation, from plain integer arithmetic.
  function automatic void calc(input int w, input logic [1:0] o,
                               input longint unsigned x, input longint unsigned y,
                               output longint unsigned h, output longint unsigned l,
                               output bit z);
    longint unsigned mask, p;
    longint sx, sy, q, r;
    bit sg;
    mask = (longint'(1) << w) - 1;
    sg = !o[0];
    sx = x;
    sy = y;
    if (sg && x[w-1]) sx = sx - (longint'(1) << w);
    if (sg && y[w-1]) sy = sy - (longint'(1) << w);
    z = 1'b0;
    if (!o[1]) begin
      if (sg) p = sx * sy;
      else    p = x * y;
      h = (p >> w) & mask;
      l = p & mask;
    end else if (y == 0) begin
      h = x;
      l = mask;
      z = 1'b1;
    end else if (sg) begin
      q = sx / sy;
      r = sx % sy;
      h = r & mask;
      l = q & mask;
    end else begin
      h = (x % y) & mask;
      l = (x / y) & mask;
    end
  endfunction

  // Cycle-level expectation: results appear W+2 edges after an accepted start.
  int              e_cnt;
  logic            e_busy, e_done, e_dbz, p_dbz;
  logic [W-1:0]    e_hi, e_lo, p_hi, p_lo;
  longint unsigned m_h, m_l;
  bit              m_z;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_cnt  <= 0;
      e_busy <= 1'b0;
      e_done <= 1'b0;
      e_dbz  <= 1'b0;
      e_hi   <= '0;
      e_lo   <= '0;
    end else begin
      e_done <= 1'b0;
      e_dbz  <= 1'b0;
      if (e_cnt == 0) begin
        if (hi_we) e_hi <= wdata;
        if (lo_we) e_lo <= wdata;
        if (start) begin
          calc(W, op, longint'(a), longint'(b), m_h, m_l, m_z);
          p_hi   <= m_h[W-1:0];
          p_lo   <= m_l[W-1:0];
          p_dbz  <= m_z;
          e_cnt  <= W + 1;
          e_busy <= 1'b1;
        end
      end else if (e_cnt == 1) begin
        e_hi   <= p_hi;
        e_lo   <= p_lo;
        e_dbz  <= p_dbz;
        e_done <= 1'b1;
        e_busy <= 1'b0;
        e_cnt  <= 0;
      end else begin
        e_cnt <= e_cnt - 1;
      end
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", busy, e_busy);
      chk("cyc_done", done, e_done);
      chk("cyc_dbz", dbz, e_dbz);
      chk("cyc_hi", hi, e_hi);
      chk("cyc_lo", lo, e_lo);
    end
  end

  // Issue an op at the current negedge; returns at the negedge of cycle 1.
  task automatic go(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // From the negedge of cycle n0, wait (bounded) for done and check latency.
  task automatic wait_done(input string name, input int n0);
    int n;
    n = n0;
    while (n < 60 && !done) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, n, 34);
  endtask

  task automatic go8(input string name, input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    int n;
    longint unsigned h, l;
    bit z;
    s8_op = o;
    s8_a = x;
    s8_b = y;
    s8_start = 1'b1;
    @(negedge clk);
    s8_start = 1'b0;
    n = 1;
    while (n < 30 && !done8) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, n, 10);
    calc(8, o, longint'(x), longint'(y), h, l, z);
    chk({name, "_model_hi"}, hi8, h);
    chk({name, "_model_lo"}, lo8, l);
    chk({name, "_model_dbz"}, dbz8, z);
  endtask

  initial begin
    int seen;
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);

    go(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_busy_c1", busy, 1);
    wait_done("multu_max", 1);
    chk("multu_max_hi", hi, 64'hFFFF_FFFE);
    chk("multu_max_lo", lo, 64'h0000_0001);
    chk("multu_max_busy_done", busy, 0);

    go(2'd0, 32'hFFFF_FFFD, 32'd5);
    chk("b2b_accept_busy", busy, 1);
    wait_done("mult_neg", 1);
    chk("mult_neg_hi", hi, 64'hFFFF_FFFF);
    chk("mult_neg_lo", lo, 64'hFFFF_FFF1);

    go(2'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", 1);
    chk("div_neg_lo", lo, 64'hFFFF_FFFD);
    chk("div_neg_hi", hi, 64'hFFFF_FFFF);

    go(2'd3, 32'd100, 32'd7);
    wait_done("divu", 1);
    chk("divu_lo", lo, 14);
    chk("divu_hi", hi, 2);

    go(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 1);
    chk("div_ovf_lo", lo, 64'h8000_0000);
    chk("div_ovf_hi", hi, 0);
    chk("div_ovf_flag", dbz, 0);

    go(2'd3, 32'h1234, 32'd0);
    wait_done("dbz", 1);
    chk("dbz_flag", dbz, 1);
    chk("dbz_hi", hi, 64'h1234);
    chk("dbz_lo", lo, 64'hFFFF_FFFF);
    @(negedge clk);
    chk("dbz_pulse_width", dbz, 0);
    chk("done_pulse_width", done, 0);

    go(2'd1, 32'd6, 32'd7);
    repeat (9) @(negedge clk);
    op = 2'd3;
    a = 32'd50;
    b = 32'd3;
    start = 1'b1;
    hi_we = 1'b1;
    wdata = 32'hAA;
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    chk("busy_ignore_hi", hi, 64'h1234);
    wait_done("mul67", 11);
    chk("mul67_hi", hi, 0);
    chk("mul67_lo", lo, 42);
    lo_we = 1'b1;
    wdata = 32'd5;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_lo", lo, 5);
    chk("mtlo_no_start", busy, 0);

    hi_we = 1'b1;
    wdata = 32'h55;
    go(2'd1, 32'd2, 32'd3);
    hi_we = 1'b0;
    chk("mthi_with_start_hi", hi, 64'h55);
    chk("mthi_with_start_busy", busy, 1);
    wait_done("mul23", 1);
    chk("mul23_hi", hi, 0);
    chk("mul23_lo", lo, 6);

    go(2'd2, 32'd1000, 32'd3);
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_hi", hi, 0);
    chk("async_rst_lo", lo, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("no_done_after_rst", seen, 0);

    go(2'd1, 32'd3, 32'd4);
    wait_done("mul34", 1);
    chk("mul34_lo", lo, 12);
    chk("mul34_hi", hi, 0);

    go8("w8_mult", 2'd0, 8'hFD, 8'h05);
    chk("w8_mult_hi", hi8, 64'hFF);
    chk("w8_mult_lo", lo8, 64'hF1);
    go8("w8_div_ovf", 2'd2, 8'h80, 8'hFF);
    chk("w8_div_ovf_lo", lo8, 64'h80);
    chk("w8_div_ovf_hi", hi8, 0);
    go8("w8_divu_zero", 2'd3, 8'hC8, 8'h00);
    chk("w8_dbz_flag", dbz8, 1);
    chk("w8_dbz_hi", hi8, 64'hC8);
    chk("w8_dbz_lo", lo8, 64'hFF);
    go8("w8_multu", 2'd1, 8'hFF, 8'hFF);
    chk("w8_multu_hi", hi8, 64'hFE);
    chk("w8_multu_lo", lo8, 64'h01);

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
